// File: rtl/logic_pkg.sv
// Shared definitions for the NAND-built logic pipeline.
//   op_e       : operation select encodings (2 bits)
//   occ_width  : width of the occupancy counter for a given stage count
package logic_pkg;

  typedef enum logic [1:0] {
    OP_NOT  = 2'b00,
    OP_NAND = 2'b01,
    OP_AND  = 2'b10,
    OP_OR   = 2'b11
  } op_e;

  // Enough bits to count 0..stages inclusive.
  function automatic int occ_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/nand_vec.sv
// Bitwise array of 2-input NAND cells; the only logic primitive in the
// logic_pipe datapath.
//   a, b : WIDTH-bit operands
//   y    : WIDTH-bit result, y[i] = ~(a[i] & b[i])
module nand_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = ~(a & b);

endmodule

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit (NOT / NAND / AND / OR) with valid/ready
// handshakes on both sides. The result is formed from NAND arrays only,
// captured in stage 0, and carried through STAGES register stages.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream handshake for a, b, op
//   a, b                : WIDTH-bit operands (b ignored for NOT)
//   op                  : 00 NOT, 01 NAND, 10 AND, 11 OR
//   out_valid/out_ready : downstream handshake for z
//   z                   : registered result (last stage)
//   occupancy           : number of valid stages currently held
module logic_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  input  logic [1:0]                      op,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                z,
  output logic [occ_width(STAGES)-1:0]    occupancy
);

  localparam int OW = occ_width(STAGES);

  // ---------------------------------------------------------------------
  // NAND-only datapath
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] nand_ab;
  logic [WIDTH-1:0] nand_aa;
  logic [WIDTH-1:0] nand_bb;
  logic [WIDTH-1:0] and_ab;
  logic [WIDTH-1:0] or_ab;
  logic [WIDTH-1:0] result;

  nand_vec #(.WIDTH(WIDTH)) u_nand_ab (.a(a),       .b(b),       .y(nand_ab));
  nand_vec #(.WIDTH(WIDTH)) u_nand_aa (.a(a),       .b(a),       .y(nand_aa));
  nand_vec #(.WIDTH(WIDTH)) u_nand_bb (.a(b),       .b(b),       .y(nand_bb));
  nand_vec #(.WIDTH(WIDTH)) u_and     (.a(nand_ab), .b(nand_ab), .y(and_ab));
  nand_vec #(.WIDTH(WIDTH)) u_or      (.a(nand_aa), .b(nand_bb), .y(or_ab));

  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_NOT:  result = nand_aa;
      OP_NAND: result = nand_ab;
      OP_AND:  result = and_ab;
      OP_OR:   result = or_ab;
      default: result = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------
  logic [STAGES-1:0]            stage_valid;
  logic [STAGES-1:0]            stage_load;
  logic [STAGES-1:0][WIDTH-1:0] stage_data;
  logic                         in_xfer;
  logic                         out_xfer;

  assign in_ready  = rst_n & stage_load[0];
  assign in_xfer   = in_valid & in_ready;
  assign out_valid = stage_valid[STAGES-1];
  assign out_xfer  = out_valid & out_ready;
  assign z         = stage_data[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_valid;
    logic [WIDTH-1:0] src_data;

    // Unrolled form of "load[k] = !valid[k] || load[k+1]": a stage may load
    // when the sink is ready or any stage from k to the end has a hole.
    // Written without the recursive chain so no bit depends on its neighbour.
    assign stage_load[k] = out_ready | ~(&stage_valid[STAGES-1:k]);

    if (k == 0) begin : g_head
      assign src_valid = in_xfer;
      assign src_data  = result;
    end else begin : g_body
      assign src_valid = stage_valid[k-1];
      assign src_data  = stage_data[k-1];
    end

    // Data only moves with a valid token so bubbles leave z untouched.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_valid[k] <= 1'b0;
        stage_data[k]  <= '0;
      end else if (stage_load[k]) begin
        stage_valid[k] <= src_valid;
        if (src_valid) begin
          stage_data[k] <= src_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10: if (occupancy != OW'(STAGES)) occupancy <= occupancy + OW'(1);
        2'b01: if (occupancy != '0)          occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe: a directed WIDTH=8/STAGES=2 instance plus
// a WIDTH x STAGES sweep of instances driven with random traffic.
module tb_logic_pipe;
  import logic_pkg::*;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int errors     = 0;
  int stall_cnt  = 0;
  int sweep_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (o)
      2'b00:   r = ~x;
      2'b01:   r = ~(x & y);
      2'b10:   r = x & y;
      default: r = x | y;
    endcase
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return r & m;
  endfunction

  // ---------------------------------------------------------------------
  // Directed instance
  // ---------------------------------------------------------------------
  logic       rst_n, rst_sw_n, in_valid, in_ready, out_valid, out_ready, chk_lat;
  logic [7:0] a, b, z;
  logic [1:0] op;
  logic [1:0] occupancy;
  sb_t        q[$];

  logic_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .occupancy (occupancy)
  );

  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      if (in_valid && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("z_order", 64'(z), e.exp);
          if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
    end
  end

  // Present one transaction and wait (bounded) until it is accepted.
  task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [63:0] exp);
    bit done = 1'b0;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{exp, cyc});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic randomize_inputs();
    op = 2'($urandom_range(0, 3));
    a  = 8'($urandom());
    b  = 8'($urandom());
  endtask

  initial begin
    int t0;
    int acc;
    rst_n     = 1'b0;
    rst_sw_n  = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b1;
    chk_lat   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_z",         64'(z),         64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst_n    = 1'b1;
    rst_sw_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Fixed-operand op table, results from hand-derived constants.
    chk_lat = 1'b1;
    send(OP_NOT,  8'hF0, 8'hCC, 64'h0F);
    send(OP_NAND, 8'hF0, 8'hCC, 64'h3F);
    send(OP_AND,  8'hF0, 8'hCC, 64'hC0);
    send(OP_OR,   8'hF0, 8'hCC, 64'hFC);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back stream.
    stall_cnt = 0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      randomize_inputs();
      send(op, a, b, model(op, 64'(a), 64'(b), 8));
    end
    check("stream_cycles", 64'(cyc - t0), 64'd16);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_stalls", 64'(stall_cnt), 64'd0);

    // Backpressure: sink stalled for 5 cycles with continuous offers.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    randomize_inputs();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) check("bp_z_stable", 64'(z), q[0].exp);
      if (in_ready) begin
        q.push_back('{model(op, 64'(a), 64'(b), 8), cyc});
        acc++;
        @(posedge clk);
        #1;
        randomize_inputs();
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check("bp_accepted",  64'(acc),       64'd2);
    check("bp_in_ready",  64'(in_ready),  64'd0);
    check("bp_occupancy", 64'(occupancy), 64'd2);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_z_hold",    64'(z),         q[0].exp);
    @(posedge clk);
    #1;

    // Full pipe, simultaneous in and out transfer.
    out_ready = 1'b1;
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd1);
    q.push_back('{model(op, 64'(a), 64'(b), 8), cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_occupancy", 64'(occupancy), 64'd2);
    repeat (4) @(posedge clk);
    #1;
    check("drain_occupancy", 64'(occupancy), 64'd0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    randomize_inputs();
    send(op, a, b, model(op, 64'(a), 64'(b), 8));
    randomize_inputs();
    send(op, a, b, model(op, 64'(a), 64'(b), 8));
    in_valid = 1'b0;
    check("pre_rst_occupancy", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_occupancy", 64'(occupancy), 64'd0);
    check("mid_rst_z",         64'(z),         64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", 64'(in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_out", 64'(out_valid), 64'd0);

    for (int i = 0; i < 2000 && sweep_done < 9; i++) @(posedge clk);
    check("sweep_done", 64'(sweep_done), 64'd9);
    check("sb_empty",   64'(q.size()),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------
  // Parameter sweep: random traffic, sink always ready, fixed latency.
  // ---------------------------------------------------------------------
  for (genvar wi = 0; wi < 3; wi++) begin : g_w
    for (genvar si = 0; si < 3; si++) begin : g_s
      localparam int W = (wi == 0) ? 1 : ((wi == 1) ? 8 : 64);
      localparam int S = (si == 0) ? 1 : ((si == 1) ? 3 : 8);

      logic                       iv, ir, ov, sor;
      logic [W-1:0]               sa, sb, sz;
      logic [1:0]                 sop;
      logic [$clog2(S+1)-1:0]     socc;
      sb_t                        sq[$];
      int                         got = 0;

      logic_pipe #(.WIDTH(W), .STAGES(S)) u_sweep (
        .clk       (clk),
        .rst_n     (rst_sw_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .a         (sa),
        .b         (sb),
        .op        (sop),
        .out_valid (ov),
        .out_ready (sor),
        .z         (sz),
        .occupancy (socc)
      );

      always @(negedge clk) begin
        sb_t e;
        if (rst_sw_n && ov) begin
          if (sq.size() == 0) begin
            check($sformatf("sweep_spurious_w%0d_s%0d", W, S), 64'd1, 64'd0);
          end else begin
            e = sq.pop_front();
            check($sformatf("sweep_z_w%0d_s%0d", W, S), 64'(sz), e.exp);
            check($sformatf("sweep_lat_w%0d_s%0d", W, S), 64'(cyc - e.cyc), 64'(S));
            got++;
          end
        end
      end

      initial begin
        logic [63:0] r1;
        logic [63:0] r2;
        int sent;
        iv   = 1'b0;
        sor  = 1'b1;
        sa   = '0;
        sb   = '0;
        sop  = '0;
        sent = 0;
        wait (rst_sw_n === 1'b1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 200 && sent < 24; n++) begin
          r1  = {$urandom(), $urandom()};
          r2  = {$urandom(), $urandom()};
          iv  = ($urandom_range(0, 3) != 0);
          sop = 2'($urandom_range(0, 3));
          sa  = r1[W-1:0];
          sb  = r2[W-1:0];
          @(negedge clk);
          if (iv && ir) begin
            sq.push_back('{model(sop, 64'(sa), 64'(sb), W), cyc});
            sent++;
          end
          @(posedge clk);
          #1;
        end
        iv = 1'b0;
        repeat (S + 3) @(posedge clk);
        #1;
        check($sformatf("sweep_count_w%0d_s%0d", W, S), 64'(got), 64'd24);
        sweep_done++;
      end
    end
  end

endmodule

// File: doc/logic_pipe.md
LOGIC_PIPE -- requirements
Module: logic_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal 1..64).
REQ-002 Parameter STAGES, default 2, number of pipeline register stages (legal 1..8).
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream presents a, b, op this cycle.
REQ-006 in_ready  output  1  block accepts the upstream transfer this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B (ignored for NOT).
REQ-009 op  input  2  operation select: 00 NOT, 01 NAND, 10 AND, 11 OR.
REQ-010 out_valid  output  1  z holds a valid result.
REQ-011 out_ready  input  1  downstream accepts z this cycle.
REQ-012 z  output  WIDTH  registered result.
REQ-013 occupancy  output  $clog2(STAGES+1)  count of valid stages currently held.

Function
REQ-014 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-015 Bitwise result SHALL be NOT: ~a; NAND: ~(a&b); AND: a&b; OR: a|b, computed per bit, no carries, width exactly WIDTH.
REQ-016 All four ops SHALL be realised only from 2-input NAND cells: NOT=nand(a,a); AND=nand(n,n) with n=nand(a,b); OR=nand(nand(a,a),nand(b,b)).
REQ-017 Result SHALL be computed combinationally from the accepted inputs and captured in stage 0; stages 1..STAGES-1 SHALL carry data and valid forward unchanged.
REQ-018 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with out_ready held high.
REQ-019 Stage k SHALL load when it is empty or stage k+1 loads (or, for the last stage, out_ready is high); otherwise it SHALL hold data and valid.
REQ-020 in_ready SHALL equal the stage-0 load condition; with out_ready high continuously, throughput SHALL be one transfer per cycle.
REQ-021 With out_ready low, the pipe SHALL fill; in_ready SHALL fall only when all STAGES stages are valid.
REQ-022 z and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-023 Simultaneous in and out transfer when full SHALL be accepted: all stages shift, occupancy unchanged.
REQ-024 occupancy SHALL increment on in-only transfer, decrement on out-only transfer, hold on both or neither; range 0..STAGES, never wraps.
REQ-025 Results SHALL emerge in acceptance order; no transaction is dropped or duplicated.
REQ-026 in_valid with in_ready low SHALL have no effect; upstream holds its data.

Reset
REQ-027 On rst_n low, all stage valid bits, out_valid and occupancy SHALL clear to 0 immediately, regardless of clk.
REQ-028 On rst_n low, z and stage data registers SHALL clear to 0.
REQ-029 During reset, in_ready SHALL be 0; after deassertion it SHALL be 1 on the first cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight results; no out_valid SHALL appear for them afterwards.

Structure
REQ-031 Op encodings (OP_NOT, OP_NAND, OP_AND, OP_OR) SHALL live in shared package logic_pkg.
REQ-032 Sub-module nand_vec (parameter WIDTH, bitwise 2-input NAND array) SHALL be instantiated for every NAND level; no other logic operators in the datapath.
REQ-033 Pipeline stages SHALL be a generate loop over STAGES; no per-stage hand-written code.

Verification
REQ-034 Reset: assert rst_n=0 mid-fill with 2 results in flight -> out_valid=0, occupancy=0, z=0 immediately; no stale output after release.
REQ-035 Ops at WIDTH=8, a=8'hF0, b=8'hCC -> NOT 8'h0F, NAND 8'h3F, AND 8'hC0, OR 8'hFC, each exactly 2 cycles after acceptance.
REQ-036 Streaming: 16 back-to-back ops, out_ready=1 -> 16 results in order, one per cycle, in_ready never drops.
REQ-037 Backpressure: out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 accepted, in_ready=0, occupancy=2, z stable; release -> drained in order.
REQ-038 Full with simultaneous in/out: occupancy=2, in_valid=1, out_ready=1 -> both transfers occur, occupancy stays 2.
REQ-039 Parameter sweep WIDTH in {1,8,64}, STAGES in {1,3,8} -> latency equals STAGES, random ops match reference model.
